// File: rtl/seq_detect_param_if.sv
// Serial pattern-detector port bundle: stream/config inputs and match outputs.
// Master drives the stream and configuration; slave is the detector.
interface seq_detect_param_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic               i_din;
    logic               i_din_vld;
    logic               i_overlap;
    logic               i_cfg_load;
    logic [MAX_LEN-1:0] i_cfg_pattern;
    logic [LEN_W-1:0]   i_cfg_len;
    logic               i_cnt_clr;
    logic               o_match;
    logic [CNT_W-1:0]   o_match_cnt;

    modport master (
        output i_din, i_din_vld, i_overlap, i_cfg_load, i_cfg_pattern, i_cfg_len, i_cnt_clr,
        input  o_match, o_match_cnt
    );

    modport slave (
        input  i_din, i_din_vld, i_overlap, i_cfg_load, i_cfg_pattern, i_cfg_len, i_cnt_clr,
        output o_match, o_match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-loadable Mealy serial-pattern detector with overlap/non-overlap matching.
// Optional saturating match counter is built only when SEQDET_COUNT_EN is defined.
module seq_detect_param #(
    parameter int unsigned        MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0101),
    parameter int unsigned        DEF_LEN     = 4,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_param_if.slave bus
);
    localparam int unsigned      LEN_W    = $clog2(MAX_LEN + 1);
    localparam int unsigned      HIST_W   = MAX_LEN - 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic [HIST_W-1:0]  r_hist;
    logic [LEN_W-1:0]   r_fill;

    logic [MAX_LEN-1:0] w_pat_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [HIST_W-1:0]  w_hist_nxt;
    logic [LEN_W-1:0]   w_fill_nxt;

    logic [MAX_LEN-1:0] w_cand;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_len_clamp;
    logic               w_hit;
    logic               w_fill_ok;
    logic               w_match;

    // Candidate window is the stored history with the live bit appended as the newest.
    assign w_cand    = {r_hist, bus.i_din};
    // A shift by MAX_LEN yields zero, so the full-length mask comes out all ones.
    assign w_mask    = (MAX_LEN'(1) << r_len) - MAX_LEN'(1);
    assign w_hit     = ((w_cand ^ r_pat) & w_mask) == '0;
    assign w_fill_ok = r_fill >= (r_len - LEN_W'(1));
    assign w_match   = bus.i_din_vld & ~bus.i_cfg_load & w_hit & w_fill_ok;

    assign bus.o_match = w_match;

    always_comb begin
        w_len_clamp = bus.i_cfg_len;
        if (bus.i_cfg_len == '0) begin
            w_len_clamp = LEN_W'(1);
        end else if (bus.i_cfg_len > LEN_MAX) begin
            w_len_clamp = LEN_MAX;
        end
    end

    // Next-state: config load flushes history; a non-overlapping match discards usable bits.
    always_comb begin
        w_pat_nxt  = r_pat;
        w_len_nxt  = r_len;
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        if (bus.i_cfg_load) begin
            w_pat_nxt  = bus.i_cfg_pattern;
            w_len_nxt  = w_len_clamp;
            w_hist_nxt = '0;
            w_fill_nxt = '0;
        end else if (bus.i_din_vld) begin
            w_hist_nxt = w_cand[HIST_W-1:0];
            if (w_match && !bus.i_overlap) begin
                w_fill_nxt = '0;
            end else if (r_fill != FILL_MAX) begin
                w_fill_nxt = r_fill + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat  <= DEF_PATTERN;
            r_len  <= LEN_W'(DEF_LEN);
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            r_pat  <= w_pat_nxt;
            r_len  <= w_len_nxt;
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Clear wins over a concurrent match; count holds at all ones.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.i_cnt_clr) begin
            w_cnt_nxt = '0;
        end else if (w_match && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign bus.o_match_cnt = r_cnt;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = bus.i_cnt_clr;
    assign bus.o_match_cnt  = CNT_W'(0);
`endif

endmodule
